down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Loadable down-counter/timer; complement of the up-counting `counter` block (same data/load/enable/out interface style).
- Counts a loaded value down to zero on enabled cycles and emits a one-cycle terminal-count pulse. Optionally auto-reloads for periodic ticks.
- Used by the processor for delay/timeout sequencing and periodic event generation.

Parameters:
- WIDTH, 8, width of data, out and the internal reload register.
- PRESCALE, 4, enabled ticks per decrement; used only when PRESCALE_EN is defined; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- data  input  WIDTH  load value.
- load  input  1  loads data into out and the reload register.
- enable  input  1  count enable; decrement qualifier.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, 1 cycle wide.
- busy  output  1  high while out != 0 and counting is pending.

Behaviour:
- All state updates on rising clk. Priority order: rst > load > enable.
- Reset (rst=1 at the edge): out=0, reload_reg=0, tc=0, busy=0, prescale counter=0. This applies mid-count and overrides load and enable in the same cycle.
- Load (load=1, rst=0):
  - Next cycle: out=data, reload_reg=data, tc=0, busy=(data!=0). Prescale counter clears.
  - Latency 1 clock.
  - Load in the same cycle as enable: load wins and no decrement occurs.
- Count step (enable=1, load=0, rst=0; with PRESCALE_EN, only on a step tick, see below):
  - out > 1: out = out-1, tc=0.
  - out == 1: tc=1 next cycle.
    - auto_reload=1: out=reload_reg, busy stays 1.
    - auto_reload=0: out=0, busy=0.
  - out == 0: hold. No wrap to all-ones, no tc, busy=0.
- enable=0: out and busy hold; tc=0 next cycle.
- tc is never high for two consecutive cycles, except in auto_reload mode with reload_reg==1. In that case out stays 1 and tc=1 on every step cycle.
- auto_reload is sampled on the terminal step only. Changing it mid-count has no other effect.
- Load with data=0: out=0, busy=0, no tc ever generated until the next nonzero load.
- Arithmetic is unsigned, WIDTH bits. Max load 2^WIDTH-1 gives exactly 2^WIDTH-1 step cycles to tc.
- One-shot tc timing: with a value N loaded and enable held high continuously from the cycle after load, tc asserts on the N-th clock after out shows N.

Optional Feature:
- Macro PRESCALE_EN.
- Defined:
  - A prescale counter (width clog2(PRESCALE), minimum 1) increments on each enable=1 cycle.
  - The count step executes only when the prescale counter reaches PRESCALE-1; the counter then wraps to 0.
  - enable=0 holds the prescale counter. load and rst clear it.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined: no prescale logic; every enable=1 cycle is a step. The PRESCALE parameter is ignored.

Test Plan:
- rst=1 for 2 cycles with load=1, data=8'd9 -> out=0, tc=0, busy=0 throughout reset. After release, load=1 pulse -> out=9, busy=1 one cycle later.
- One-shot: load 8'd3, auto_reload=0, enable=1 held -> out 3,2,1,0 on successive cycles; tc=1 only in the cycle out becomes 0; busy falls with it. Further enables keep out=0 with no tc and no wrap to 8'hFF.
- Periodic: load 8'd4, auto_reload=1, enable=1 for 12 cycles -> out sequence 4,3,2,1,4,3,2,1,...; tc pulses every 4th cycle, coincident with out returning to 4.
- Priority/pauses:
  - Load 8'd5, enable for 2 cycles (out=3), enable=0 for 3 cycles -> out holds 3.
  - Then load=1, enable=1, data=8'd55 same cycle -> out=55, no decrement that cycle.
  - Then rst=1 mid-count -> out=0 next cycle.
- Edge values:
  - Load 8'd0 with enable=1 -> out=0, busy=0, tc never asserts.
  - Load 8'd1, auto_reload=1 -> tc high every enabled cycle, out stays 1.
  - Load 8'd255, auto_reload=0 -> tc after exactly 255 enabled cycles.
- PRESCALE_EN defined, PRESCALE=4: load 8'd2, enable=1 -> out=1 after 4 enabled cycles, tc after 8. Dropping enable for 2 cycles mid-period delays tc by exactly 2 cycles.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and optional auto-reload.
// Define PRESCALE_EN to require PRESCALE enabled cycles per decrement.
module down_counter_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] reload_reg;
    logic             step;

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("PRESCALE must be >= 1");
        end
    endgenerate

`ifdef PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_reg;

    // A decrement fires on the enabled cycle where the prescaler sits at its last value.
    assign step = enable && (ps_reg == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            ps_reg <= '0;
        end else if (enable) begin
            ps_reg <= (ps_reg == PS_LAST) ? '0 : ps_reg + 1'b1;
        end
    end
`else
    assign step = enable;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
        end else if (load) begin
            out        <= data;
            reload_reg <= data;
            tc         <= 1'b0;
            busy       <= (data != '0);
        end else if (step) begin
            tc <= 1'b0;
            if (out > ONE) begin
                out <= out - ONE;
            end else if (out == ONE) begin
                // Terminal step: auto_reload is only consulted here.
                tc <= 1'b1;
                if (auto_reload) begin
                    out  <= reload_reg;
                    busy <= (reload_reg != '0);
                end else begin
                    out  <= '0;
                    busy <= 1'b0;
                end
            end else begin
                busy <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus pushes expected outputs, a monitor
// pops and compares one entry per clock. Prescale checks run only with PRESCALE_EN.
module tb_down_counter_timer;

    typedef struct {
        string      name;
        logic       which;
        logic [7:0] out;
        logic       tc;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'd9;
    logic       load = 1'b1;
    logic       enable = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] out;
    logic       tc;
    logic       busy;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .data(data), .load(load), .enable(enable),
        .auto_reload(auto_reload), .out(out), .tc(tc), .busy(busy)
    );

`ifdef PRESCALE_EN
    logic [7:0] ps_out;
    logic       ps_tc;
    logic       ps_busy;

    down_counter_timer #(.WIDTH(8), .PRESCALE(4)) dut_ps (
        .clk(clk), .rst(rst), .data(data), .load(load), .enable(enable),
        .auto_reload(auto_reload), .out(ps_out), .tc(ps_tc), .busy(ps_busy)
    );
`endif

    // Monitor: one expectation per clock, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] a_out;
            logic       a_tc;
            logic       a_busy;
            e = exp_q.pop_front();
            a_out  = out;
            a_tc   = tc;
            a_busy = busy;
`ifdef PRESCALE_EN
            if (e.which) begin
                a_out  = ps_out;
                a_tc   = ps_tc;
                a_busy = ps_busy;
            end
`endif
            tests_run++;
            if (a_out !== e.out || a_tc !== e.tc || a_busy !== e.busy) begin
                tests_failed++;
                $display("FAIL %s: got out=%0d tc=%b busy=%b, expected out=%0d tc=%b busy=%b",
                         e.name, a_out, a_tc, a_busy, e.out, e.tc, e.busy);
            end else begin
                $display("ok   %s: out=%0d tc=%b busy=%b", e.name, a_out, a_tc, a_busy);
            end
        end
    end

    task automatic cyc(input logic r, input logic l, input logic [7:0] d, input logic en,
                       input logic ar, input logic [7:0] eo, input logic etc, input logic eb,
                       input string nm, input logic w = 1'b0);
        exp_t e;
        @(negedge clk);
        rst = r; load = l; data = d; enable = en; auto_reload = ar;
        e.name = nm; e.which = w; e.out = eo; e.tc = etc; e.busy = eb;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset with load asserted must still clear everything.
        cyc(1, 1, 8'd9, 0, 0, 8'd0, 0, 0, "rst_a");
        cyc(1, 1, 8'd9, 1, 0, 8'd0, 0, 0, "rst_b");
        cyc(0, 1, 8'd9, 0, 0, 8'd9, 0, 1, "load9");

        // One-shot countdown, then hold at zero without wrap.
        cyc(0, 1, 8'd3, 0, 0, 8'd3, 0, 1, "os_load3");
        cyc(0, 0, 8'd0, 1, 0, 8'd2, 0, 1, "os_2");
        cyc(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "os_1");
        cyc(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, "os_0_tc");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, "os_hold0");

        // Periodic mode: tc every 4th step as out returns to 4.
        cyc(0, 1, 8'd4, 0, 1, 8'd4, 0, 1, "per_load4");
        for (int i = 0; i < 12; i++) begin
            int k;
            k = (i + 1) % 4;
            cyc(0, 0, 8'd0, 1, 1, 8'(4 - k), (k == 0), 1, "per_step");
        end

        // Pauses and priority.
        cyc(0, 1, 8'd5, 0, 0, 8'd5, 0, 1, "pri_load5");
        cyc(0, 0, 8'd0, 1, 0, 8'd4, 0, 1, "pri_4");
        cyc(0, 0, 8'd0, 1, 0, 8'd3, 0, 1, "pri_3");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 8'd0, 0, 0, 8'd3, 0, 1, "pri_hold3");
        cyc(0, 1, 8'd55, 1, 0, 8'd55, 0, 1, "pri_load_wins");
        cyc(0, 0, 8'd0, 1, 0, 8'd54, 0, 1, "pri_54");
        cyc(1, 1, 8'd7, 1, 0, 8'd0, 0, 0, "pri_rst_mid");

        // Zero load: no tc ever.
        cyc(0, 1, 8'd0, 1, 0, 8'd0, 0, 0, "zero_load");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 8'd0, 1, 1, 8'd0, 0, 0, "zero_hold");

        // Reload value 1 in periodic mode: tc on every step.
        cyc(0, 1, 8'd1, 0, 1, 8'd1, 0, 1, "one_load");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 8'd0, 1, 1, 8'd1, 1, 1, "one_tc");
        cyc(0, 0, 8'd0, 0, 1, 8'd1, 0, 1, "one_pause");

        // auto_reload only matters on the terminal step.
        cyc(0, 1, 8'd2, 0, 0, 8'd2, 0, 1, "ar_load2");
        cyc(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "ar_1");
        cyc(0, 0, 8'd0, 1, 1, 8'd2, 1, 1, "ar_reload");

        // Maximum load: tc after exactly 255 steps.
        cyc(0, 1, 8'd255, 0, 0, 8'd255, 0, 1, "max_load");
        for (int i = 1; i <= 255; i++)
            cyc(0, 0, 8'd0, 1, 0, 8'(255 - i), (i == 255), (i != 255), "max_step");
        cyc(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, "max_nowrap");

`ifdef PRESCALE_EN
        // PRESCALE=4: one decrement per 4 enabled cycles.
        cyc(0, 1, 8'd2, 0, 0, 8'd2, 0, 1, "ps_load2", 1'b1);
        for (int k = 1; k <= 8; k++)
            cyc(0, 0, 8'd0, 1, 0, (k < 4) ? 8'd2 : ((k < 8) ? 8'd1 : 8'd0),
                (k == 8), (k != 8), "ps_step", 1'b1);
        // Same run with a 2-cycle enable gap: tc lands 2 cycles later.
        cyc(0, 1, 8'd2, 0, 0, 8'd2, 0, 1, "ps_reload2", 1'b1);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 10; c++) begin
                logic en;
                en = !(c == 2 || c == 3);
                if (en) k++;
                cyc(0, 0, 8'd0, en, 0, (k < 4) ? 8'd2 : ((k < 8) ? 8'd1 : 8'd0),
                    (en && k == 8), (k != 8), "ps_gap", 1'b1);
            end
        end
`endif

        @(negedge clk);
        enable = 1'b0;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
